checkpoint_monitor: RTL and testbench
=====================================

CHECKPOINT_MONITOR -- requirements
Module: checkpoint_monitor

Interface
REQ-001 The block SHALL expose these parameters:
- WIDTH, 16, status word width.
- NUM_CKPT, 2, number of ordered checkpoints (1..8).
- STABLE_CYCLES, 4, consecutive equal samples that qualify a value (2..15).
- TIMEOUT_CYCLES, 75000, cycle budget from enable to pass (32-bit counter).
REQ-002 The block SHALL use one clock, wb_clk_i; reset wb_rst_i is asynchronous and active-high.
REQ-003 The block SHALL expose these ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  async active-high reset.
- enable_i  in  1  arm monitor; low returns it to IDLE.
- fail_on_unexp_i  in  1  unexpected qualified value after start forces FAIL.
- status_i  in  WIDTH  asynchronous status word from the mprj_io[31:16] pads.
- ckpt_table_i  in  NUM_CKPT*WIDTH  expected values; entry 0 in the LSBs.
- qual_o  out  1  one-cycle pulse when a new value qualifies.
- qual_value_o  out  WIDTH  last qualified value.
- ckpt_idx_o  out  3  index of next expected checkpoint.
- started_o, pass_o, fail_o, timeout_o, done_o  out  1 each  status flags; done_o = pass|fail|timeout.

Function
REQ-004 status_i SHALL pass through a 2-flop synchronizer per bit before any use.
REQ-005 The filter SHALL count consecutive cycles with an unchanged synchronized word, resetting on any change.
REQ-006 qual_o SHALL pulse exactly once per stable stretch, on the cycle the count reaches STABLE_CYCLES; qual_value_o updates the same cycle.
REQ-007 Latency SHALL be exactly 2+STABLE_CYCLES cycles from the first edge sampling a new value to qual_o.
REQ-008 Stretches shorter than STABLE_CYCLES SHALL produce no qual_o.
REQ-009 The FSM SHALL have states IDLE, WAIT_FIRST, TRACK, PASS, FAIL, TIMEOUT.
REQ-010 IDLE -> WAIT_FIRST on enable_i high; the timeout counter clears and starts counting that cycle.
REQ-011 In WAIT_FIRST, a qualified value equal to entry 0 SHALL set started_o and ckpt_idx_o=1, entering TRACK, or PASS if NUM_CKPT=1; other values SHALL be ignored.
REQ-012 In TRACK, a qualified value equal to entry ckpt_idx_o SHALL increment ckpt_idx_o; matching the last entry SHALL enter PASS.
REQ-013 In TRACK, a qualified value equal to neither the current nor the previous entry SHALL enter FAIL if fail_on_unexp_i=1 and be ignored otherwise.
REQ-014 In WAIT_FIRST or TRACK, the counter reaching TIMEOUT_CYCLES SHALL enter TIMEOUT.
REQ-015 If a final-checkpoint match and timeout expiry occur in the same cycle, PASS SHALL win.
REQ-016 PASS, FAIL and TIMEOUT SHALL be sticky until enable_i falls, which returns the FSM to IDLE.
REQ-017 enable_i low in any state SHALL return to IDLE and clear started_o, ckpt_idx_o, the flags and the counter within one cycle.
REQ-018 The timeout counter SHALL saturate and never wrap.

Reset
REQ-019 Reset SHALL force state IDLE, all synchronizer and filter registers to 0, qual_value_o=0, ckpt_idx_o=0, and all flags and qual_o low.
REQ-020 Reset asserted mid-TRACK SHALL clear state immediately; after release the block requires enable_i to be low and then high again before re-arming.

Structure
REQ-021 The package checkpoint_monitor_pkg SHALL hold the state enum, the ckpt index width constant and the default parameter values.
REQ-022 The synchronizer and stability filter SHALL be a sub-module named status_qualifier, with outputs qual and value.

Verification
REQ-023 Entries {AB60, AB61}; drive 0000, then AB60 held 10 cycles, then AB61 -> started_o 6 cycles after AB60, pass_o 6 cycles after AB61, ckpt_idx_o=2.
REQ-024 After AB60 qualifies, pulse AB61 for 3 cycles then return to AB60 -> no qual_o for AB61, pass_o stays low.
REQ-025 TIMEOUT_CYCLES=200; hold 0000 -> timeout_o at cycle 200 after enable, done_o=1, pass_o=0.
REQ-026 fail_on_unexp_i=1; AB60 then 1234 stable -> fail_o high; repeat with fail_on_unexp_i=0 -> ignored, AB61 then passes.
REQ-027 Assert wb_rst_i mid-TRACK at ckpt_idx_o=1 -> all outputs 0 asynchronously; after release with enable_i cycled, the full AB60/AB61 sequence passes.
REQ-028 Align AB61 qualification with cycle TIMEOUT_CYCLES -> pass_o=1, timeout_o=0.

Source files
------------

// File: rtl/checkpoint_monitor_pkg.sv
// Shared types and constants for the checkpoint monitor.
package checkpoint_monitor_pkg;

    localparam int CKPT_IDX_W         = 3;
    localparam int STAB_CNT_W         = 4;

    localparam int DEF_WIDTH          = 16;
    localparam int DEF_NUM_CKPT       = 2;
    localparam int DEF_STABLE_CYCLES  = 4;
    localparam int DEF_TIMEOUT_CYCLES = 75000;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FIRST = 3'd1,
        ST_TRACK      = 3'd2,
        ST_PASS       = 3'd3,
        ST_FAIL       = 3'd4,
        ST_TIMEOUT    = 3'd5
    } state_e;

    // Advance the checkpoint index, holding at the top code so an
    // eight-entry table ends at 7 instead of wrapping back to 0.
    function automatic logic [CKPT_IDX_W-1:0] idx_inc(input logic [CKPT_IDX_W-1:0] idx);
        logic [CKPT_IDX_W-1:0] nxt;
        if (idx == {CKPT_IDX_W{1'b1}}) begin
            nxt = idx;
        end else begin
            nxt = idx + {{(CKPT_IDX_W-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/checkpoint_monitor_status_qualifier.sv
// Two-flop synchronizer followed by a stability filter: a word qualifies
// after STABLE_CYCLES consecutive identical synchronized samples.
module status_qualifier
    import checkpoint_monitor_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] status_i,
    output logic             qual,
    output logic [WIDTH-1:0] value
);

    localparam logic [STAB_CNT_W-1:0] CNT_ONE    = STAB_CNT_W'(1);
    localparam logic [STAB_CNT_W-1:0] STABLE_MAX = STAB_CNT_W'(STABLE_CYCLES);
    localparam logic [STAB_CNT_W-1:0] STABLE_PRE = STAB_CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0]      sync1_q, sync1_d;
    logic [WIDTH-1:0]      sync2_q, sync2_d;
    logic [WIDTH-1:0]      last_q, last_d;
    logic [WIDTH-1:0]      value_q, value_d;
    logic [STAB_CNT_W-1:0] cnt_q, cnt_d;
    logic                  qual_q, qual_d;

    // Next-state: shift the synchronizer, count the run length, and pulse
    // once when the run reaches its qualifying length (count saturates so
    // a long stretch never re-fires).
    always_comb begin
        sync1_d = status_i;
        sync2_d = sync1_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        qual_d  = 1'b0;
        value_d = value_q;
        if (sync2_q != last_q) begin
            last_d = sync2_q;
            cnt_d  = CNT_ONE;
        end else begin
            if (cnt_q < STABLE_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
            if (cnt_q == STABLE_PRE) begin
                qual_d  = 1'b1;
                value_d = sync2_q;
            end else begin
                qual_d  = 1'b0;
                value_d = value_q;
            end
        end
    end

    // Synchronizer and filter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            qual_q  <= 1'b0;
            value_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            qual_q  <= qual_d;
            value_q <= value_d;
        end
    end

    assign qual  = qual_q;
    assign value = value_q;

endmodule

// File: rtl/checkpoint_monitor.sv
// Watches a qualified status word for an ordered list of checkpoint values
// and reports pass, fail (unexpected value) or timeout.
module checkpoint_monitor
    import checkpoint_monitor_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int NUM_CKPT       = DEF_NUM_CKPT,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      enable_i,
    input  logic                      fail_on_unexp_i,
    input  logic [WIDTH-1:0]          status_i,
    input  logic [NUM_CKPT*WIDTH-1:0] ckpt_table_i,
    output logic                      qual_o,
    output logic [WIDTH-1:0]          qual_value_o,
    output logic [CKPT_IDX_W-1:0]     ckpt_idx_o,
    output logic                      started_o,
    output logic                      pass_o,
    output logic                      fail_o,
    output logic                      timeout_o,
    output logic                      done_o
);

    localparam logic [CKPT_IDX_W-1:0] LAST_IDX    = CKPT_IDX_W'(NUM_CKPT - 1);
    localparam logic [31:0]           TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

    logic             qual_s;
    logic [WIDTH-1:0] value_s;
    logic [WIDTH-1:0] cur_entry_s, prev_entry_s;
    logic             match_s, last_s, expired_s;
    logic [31:0]      tcnt_inc_s;

    state_e                state_q, state_d;
    logic [CKPT_IDX_W-1:0] ckpt_idx_q, ckpt_idx_d;
    logic [31:0]           tcnt_q, tcnt_d;
    logic [WIDTH-1:0]      qual_value_q, qual_value_d;
    logic                  qual_q, qual_d;
    logic                  started_q, started_d;
    logic                  pass_q, pass_d;
    logic                  fail_q, fail_d;
    logic                  timeout_q, timeout_d;
    logic                  done_q, done_d;
    logic                  arm_ok_q, arm_ok_d;

    status_qualifier #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_qual (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .status_i (status_i),
        .qual     (qual_s),
        .value    (value_s)
    );

    // Select the expected entry and the one just matched from the table.
    always_comb begin
        cur_entry_s  = '0;
        prev_entry_s = '0;
        for (int i = 0; i < NUM_CKPT; i++) begin
            if (ckpt_idx_q == CKPT_IDX_W'(i)) begin
                cur_entry_s = ckpt_table_i[i*WIDTH +: WIDTH];
            end else begin
                cur_entry_s = cur_entry_s;
            end
            if (ckpt_idx_q == CKPT_IDX_W'(i + 1)) begin
                prev_entry_s = ckpt_table_i[i*WIDTH +: WIDTH];
            end else begin
                prev_entry_s = prev_entry_s;
            end
        end
    end

    assign match_s    = qual_s && (value_s == cur_entry_s);
    assign last_s     = (ckpt_idx_q == LAST_IDX);
    assign expired_s  = (tcnt_q >= TIMEOUT_LIM);
    assign tcnt_inc_s = (tcnt_q == 32'hFFFF_FFFF) ? tcnt_q : tcnt_q + 32'd1;

    // Checkpoint FSM next-state: a final match beats a same-cycle timeout;
    // re-arming after reset needs enable_i to have been seen low first.
    always_comb begin
        state_d      = state_q;
        ckpt_idx_d   = ckpt_idx_q;
        tcnt_d       = tcnt_q;
        started_d    = started_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        timeout_d    = timeout_q;
        done_d       = done_q;
        qual_d       = qual_s;
        qual_value_d = qual_s ? value_s : qual_value_q;
        arm_ok_d     = enable_i ? arm_ok_q : 1'b1;
        if (!enable_i) begin
            state_d    = ST_IDLE;
            ckpt_idx_d = '0;
            tcnt_d     = 32'd0;
            started_d  = 1'b0;
            pass_d     = 1'b0;
            fail_d     = 1'b0;
            timeout_d  = 1'b0;
            done_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm_ok_q) begin
                        state_d    = ST_WAIT_FIRST;
                        tcnt_d     = 32'd1;
                        ckpt_idx_d = '0;
                        started_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT_FIRST, ST_TRACK: begin
                    tcnt_d = tcnt_inc_s;
                    if (match_s && last_s) begin
                        state_d    = ST_PASS;
                        ckpt_idx_d = idx_inc(ckpt_idx_q);
                        started_d  = 1'b1;
                        pass_d     = 1'b1;
                        done_d     = 1'b1;
                    end else if (expired_s) begin
                        state_d   = ST_TIMEOUT;
                        timeout_d = 1'b1;
                        done_d    = 1'b1;
                    end else if (match_s) begin
                        state_d    = ST_TRACK;
                        ckpt_idx_d = idx_inc(ckpt_idx_q);
                        started_d  = 1'b1;
                    end else if (qual_s && (state_q == ST_TRACK) &&
                                 (value_s != prev_entry_s) && fail_on_unexp_i) begin
                        state_d = ST_FAIL;
                        fail_d  = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= ST_IDLE;
            ckpt_idx_q   <= '0;
            tcnt_q       <= 32'd0;
            started_q    <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            timeout_q    <= 1'b0;
            done_q       <= 1'b0;
            qual_q       <= 1'b0;
            qual_value_q <= '0;
            arm_ok_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ckpt_idx_q   <= ckpt_idx_d;
            tcnt_q       <= tcnt_d;
            started_q    <= started_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            timeout_q    <= timeout_d;
            done_q       <= done_d;
            qual_q       <= qual_d;
            qual_value_q <= qual_value_d;
            arm_ok_q     <= arm_ok_d;
        end
    end

    assign qual_o       = qual_q;
    assign qual_value_o = qual_value_q;
    assign ckpt_idx_o   = ckpt_idx_q;
    assign started_o    = started_q;
    assign pass_o       = pass_q;
    assign fail_o       = fail_q;
    assign timeout_o    = timeout_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_checkpoint_monitor.sv
// Self-checking bench: directed scenarios plus randomized status streams,
// every cycle compared against a window/elapsed-time reference model.
module tb_checkpoint_monitor;

    localparam int W = 16;
    localparam int N = 2;
    localparam int S = 4;
    localparam int T = 200;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           en  = 1'b0;
    logic           fou = 1'b0;
    logic [W-1:0]   status = '0;
    logic [N*W-1:0] table_v;
    logic           qual_o, started_o, pass_o, fail_o, timeout_o, done_o;
    logic [W-1:0]   qual_value_o;
    logic [2:0]     ckpt_idx_o;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] entries [N];

    // reference model state
    logic [W:0]   hist [$];
    bit           m_arm_ok, m_active, m_started, m_qual;
    int           m_idx, m_outcome, m_e0;   // outcome: 0 none, 1 pass, 2 fail, 3 timeout
    logic [W-1:0] m_qval;

    checkpoint_monitor #(
        .WIDTH(W), .NUM_CKPT(N), .STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)
    ) dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .enable_i        (en),
        .fail_on_unexp_i (fou),
        .status_i        (status),
        .ckpt_table_i    (table_v),
        .qual_o          (qual_o),
        .qual_value_o    (qual_value_o),
        .ckpt_idx_o      (ckpt_idx_o),
        .started_o       (started_o),
        .pass_o          (pass_o),
        .fail_o          (fail_o),
        .timeout_o       (timeout_o),
        .done_o          (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reset state corresponds to a zero run that began one sample before the
    // first edge, preceded by a sample that matches nothing.
    task automatic model_reset();
        hist.delete();
        hist.push_back(17'h10000);
        hist.push_back(17'h00000);
        hist.push_back(17'h00000);
        m_arm_ok = 1'b0; m_active = 1'b0; m_started = 1'b0; m_qual = 1'b0;
        m_idx = 0; m_outcome = 0; m_e0 = 0; m_qval = '0;
    endtask

    // A value qualifies at edge k when the S samples taken at edges k-S-2..k-3
    // are equal and the sample before them differs.
    task automatic model_edge();
        int k; bit q; bit ok_prev; bit hit; logic [W-1:0] v;
        hist.push_back({1'b0, status});
        k = hist.size() - 1;
        q = 1'b0; v = '0;
        if (k - S - 3 >= 0) begin
            q = 1'b1;
            for (int j = k - S - 2; j <= k - 3; j++) if (hist[j] !== hist[k-3]) q = 1'b0;
            if (hist[k-S-3] === hist[k-3]) q = 1'b0;
            v = hist[k-3][W-1:0];
        end
        m_qual = q;
        if (q) m_qval = v;
        ok_prev = m_arm_ok;
        if (!en) m_arm_ok = 1'b1;
        if (!en) begin
            m_active = 1'b0; m_started = 1'b0; m_idx = 0; m_outcome = 0;
        end else if (!m_active && m_outcome == 0) begin
            if (ok_prev) begin m_active = 1'b1; m_e0 = k; m_idx = 0; m_started = 1'b0; end
        end else if (m_active) begin
            hit = q && (v == entries[m_idx]);
            if (hit && m_idx == N - 1) begin
                m_idx++; m_started = 1'b1; m_outcome = 1; m_active = 1'b0;
            end else if (k - m_e0 >= T) begin
                m_outcome = 3; m_active = 1'b0;
            end else if (hit) begin
                m_idx++; m_started = 1'b1;
            end else if (q && m_started && fou && v != entries[m_idx-1]) begin
                m_outcome = 2; m_active = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        chk("qual_o",       32'(qual_o),       32'(m_qual));
        chk("qual_value_o", 32'(qual_value_o), 32'(m_qval));
        chk("ckpt_idx_o",   32'(ckpt_idx_o),   32'(m_idx));
        chk("started_o",    32'(started_o),    32'(m_started));
        chk("pass_o",       32'(pass_o),       32'(m_outcome == 1));
        chk("fail_o",       32'(fail_o),       32'(m_outcome == 2));
        chk("timeout_o",    32'(timeout_o),    32'(m_outcome == 3));
        chk("done_o",       32'(done_o),       32'(m_outcome != 0));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic hold(input logic [W-1:0] v, input int n);
        status = v;
        repeat (n) step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_qual"},  32'(qual_o),       32'd0);
        chk({tag, "_qval"},  32'(qual_value_o), 32'd0);
        chk({tag, "_idx"},   32'(ckpt_idx_o),   32'd0);
        chk({tag, "_start"}, 32'(started_o),    32'd0);
        chk({tag, "_flags"}, 32'({pass_o, fail_o, timeout_o, done_o}), 32'd0);
    endtask

    initial begin
        int ab61_quals;
        int r;
        entries[0] = 16'hAB60;
        entries[1] = 16'hAB61;
        table_v    = {16'hAB61, 16'hAB60};

        // power-on reset
        #1 rst = 1'b1;
        @(negedge clk);
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        hold(16'h0000, 2);

        // ordered pass with exact latencies
        en = 1'b1; fou = 1'b0;
        hold(16'h0000, 8);
        hold(16'hAB60, 6);
        chk("A_started_early", 32'(started_o), 32'd0);
        step();
        chk("A_started", 32'(started_o), 32'd1);
        chk("A_qual", 32'(qual_o), 32'd1);
        chk("A_qval", 32'(qual_value_o), 32'h0000AB60);
        chk("A_idx1", 32'(ckpt_idx_o), 32'd1);
        hold(16'hAB60, 3);
        hold(16'hAB61, 6);
        chk("A_pass_early", 32'(pass_o), 32'd0);
        step();
        chk("A_pass", 32'(pass_o), 32'd1);
        chk("A_idx2", 32'(ckpt_idx_o), 32'd2);
        chk("A_done", 32'(done_o), 32'd1);
        hold(16'hAB61, 3);
        chk("A_pass_sticky", 32'(pass_o), 32'd1);
        en = 1'b0;
        step();
        chk("A_disable_clears", 32'({started_o, pass_o, done_o, ckpt_idx_o}), 32'd0);

        // short glitch of the next value must not qualify
        en = 1'b1; fou = 1'b1;
        hold(16'h0000, 4);
        hold(16'hAB60, 10);
        chk("B_started", 32'(started_o), 32'd1);
        ab61_quals = 0;
        status = 16'hAB61;
        for (int i = 0; i < 3; i++) begin step(); if (qual_o && qual_value_o == 16'hAB61) ab61_quals++; end
        status = 16'hAB60;
        for (int i = 0; i < 10; i++) begin step(); if (qual_o && qual_value_o == 16'hAB61) ab61_quals++; end
        chk("B_no_glitch_qual", 32'(ab61_quals), 32'd0);
        chk("B_pass_low", 32'(pass_o), 32'd0);
        chk("B_fail_low", 32'(fail_o), 32'd0);
        chk("B_idx", 32'(ckpt_idx_o), 32'd1);
        en = 1'b0;
        step();

        // timeout exactly T cycles after enable
        en = 1'b1; fou = 1'b0;
        hold(16'h0000, 200);
        chk("C_timeout_early", 32'(timeout_o), 32'd0);
        step();
        chk("C_timeout", 32'(timeout_o), 32'd1);
        chk("C_done", 32'(done_o), 32'd1);
        chk("C_pass", 32'(pass_o), 32'd0);
        en = 1'b0;
        step();

        // unexpected value with and without fail_on_unexp_i
        en = 1'b1; fou = 1'b1;
        hold(16'h0000, 4);
        hold(16'hAB60, 8);
        hold(16'h1234, 8);
        chk("D_fail", 32'(fail_o), 32'd1);
        chk("D_fail_done", 32'(done_o), 32'd1);
        en = 1'b0;
        step();
        en = 1'b1; fou = 1'b0;
        hold(16'h0000, 4);
        hold(16'hAB60, 8);
        hold(16'h1234, 8);
        chk("D_ignored", 32'(fail_o), 32'd0);
        hold(16'hAB61, 8);
        chk("D_pass", 32'(pass_o), 32'd1);
        en = 1'b0;
        step();

        // asynchronous reset mid-track, then re-arm only after enable cycles
        en = 1'b1;
        hold(16'h0000, 4);
        hold(16'hAB60, 8);
        chk("E_idx1", 32'(ckpt_idx_o), 32'd1);
        #2 rst = 1'b1;
        #1 chk_all_zero("E_async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        hold(16'hAB60, 8);
        chk("E_no_rearm", 32'(started_o), 32'd0);
        en = 1'b0;
        step();
        en = 1'b1;
        hold(16'h0000, 4);
        hold(16'hAB60, 8);
        hold(16'hAB61, 8);
        chk("E_pass", 32'(pass_o), 32'd1);
        chk("E_idx2", 32'(ckpt_idx_o), 32'd2);
        en = 1'b0;
        step();

        // final match on the expiry cycle: pass wins
        en = 1'b1; fou = 1'b1;
        hold(16'h0000, 10);
        hold(16'hAB60, 184);
        hold(16'hAB61, 6);
        chk("F_pass_early", 32'(pass_o), 32'd0);
        chk("F_timeout_early", 32'(timeout_o), 32'd0);
        step();
        chk("F_pass", 32'(pass_o), 32'd1);
        chk("F_timeout", 32'(timeout_o), 32'd0);
        en = 1'b0;
        step();

        // randomized streams
        en = 1'b1; fou = 1'b0;
        for (int seg = 0; seg < 150; seg++) begin
            if ($urandom_range(0, 7) == 0) begin
                en = 1'b0;
                repeat ($urandom_range(1, 3)) step();
                en = 1'b1;
                fou = 1'($urandom_range(0, 1));
            end
            r = int'($urandom_range(0, 4));
            case (r)
                0: status = 16'hAB60;
                1: status = 16'hAB61;
                2: status = 16'h1234;
                3: status = 16'h0000;
                default: status = 16'($urandom());
            endcase
            repeat ($urandom_range(1, 8)) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
